// File: rtl/da_capture_buf.sv
// Multi-channel D-A sample capture buffer: armed/triggered one-shot or ring capture
// with status flags and a latency-1 random-access readback port once capture is done.
module da_capture_buf #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 910,
  parameter int unsigned AW    = 10,
  parameter int unsigned NCH   = 2,
  parameter int unsigned CW    = 3
) (
  input  logic              dack,
  input  logic              reset_n,
  input  logic              we,
  input  logic [NCH*DW-1:0] din,
  input  logic [NCH-1:0]    ch_en,
  input  logic              mode,
  input  logic              arm,
  input  logic              trig,
  input  logic              stop,
  input  logic              clr,
  input  logic              rd_req,
  input  logic [CW-1:0]     rd_ch,
  input  logic [AW-1:0]     rd_addr,
  output logic [DW-1:0]     rd_data,
  output logic              rd_valid,
  output logic [1:0]        state_o,
  output logic [AW:0]       count,
  output logic              wrapped,
  output logic              overflow
);

  localparam int unsigned IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW:0]    count_q, count_d;
  logic           wrapped_q, wrapped_d;
  logic           overflow_q, overflow_d;
  logic           mode_q, mode_d;
  logic [NCH-1:0] ch_en_q, ch_en_d;
  logic [DW-1:0]  rd_data_q, rd_data_d;
  logic           rd_valid_q, rd_valid_d;
  logic           wr_en;

  logic [DW-1:0]  mem_q [NCH][DEPTH];

  logic [AW:0]    sum;
  logic [AW-1:0]  phys;
  logic [DW-1:0]  sel;
  logic           hit;

  // Capture control: clr overrides everything, stop beats trig in ARMED
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    wrapped_d  = wrapped_q;
    overflow_d = overflow_q;
    mode_d     = mode_q;
    ch_en_d    = ch_en_q;
    wr_en      = 1'b0;
    if (clr) begin
      state_d    = S_IDLE;
      count_d    = '0;
      wrapped_d  = 1'b0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_d    = S_ARMED;
            ch_en_d    = ch_en;
            mode_d     = mode;
            wptr_d     = '0;
            count_d    = '0;
            wrapped_d  = 1'b0;
            overflow_d = 1'b0;
          end
        end
        S_ARMED: begin
          if (stop) begin
            state_d = S_DONE;
          end else if (trig) begin
            state_d = S_CAPTURE;
            wr_en   = we;
          end
        end
        S_CAPTURE: begin
          wr_en = we;
          if (stop) state_d = S_DONE;
        end
        S_DONE: begin
          if (we && !mode_q) overflow_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
      if (wr_en) begin
        wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
        if (count_q != DEPTH_W) count_d = count_q + 1'b1;
        // A full ring that writes slot 0 again has started overwriting
        if (mode_q && (wptr_q == '0) && (count_q == DEPTH_W)) wrapped_d = 1'b1;
        if (!mode_q && ((count_q + 1'b1) == DEPTH_W)) state_d = S_DONE;
      end
    end
  end

  // Readback: once wrapped, the write pointer marks the oldest sample
  always_comb begin
    sum = {1'b0, wptr_q} + {1'b0, rd_addr};
    if (!wrapped_q)          phys = rd_addr;
    else if (sum >= DEPTH_W) phys = AW'(sum - DEPTH_W);
    else                     phys = sum[AW-1:0];
    sel = '0;
    hit = 1'b0;
    for (int k = 0; k < int'(NCH); k++) begin
      if (({1'b0, rd_ch} == (CW+1)'(k)) && ch_en_q[k]) begin
        sel = mem_q[k][IW'(phys)];
        hit = 1'b1;
      end
    end
    hit        = hit && ({1'b0, rd_addr} < count_q);
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    if ((state_q == S_DONE) && rd_req) begin
      rd_valid_d = 1'b1;
      rd_data_d  = hit ? sel : '0;
    end
  end

  always_ff @(posedge dack or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      count_q    <= '0;
      wrapped_q  <= 1'b0;
      overflow_q <= 1'b0;
      mode_q     <= 1'b0;
      ch_en_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      wrapped_q  <= wrapped_d;
      overflow_q <= overflow_d;
      mode_q     <= mode_d;
      ch_en_q    <= ch_en_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Sample storage is deliberately not reset
  always_ff @(posedge dack) begin
    if (wr_en) begin
      for (int k = 0; k < int'(NCH); k++) begin
        if (ch_en_q[k]) mem_q[k][IW'(wptr_q)] <= din[k*DW +: DW];
      end
    end
  end

  assign state_o  = state_q;
  assign count    = count_q;
  assign wrapped  = wrapped_q;
  assign overflow = overflow_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_da_capture_buf.sv
// Bench for da_capture_buf: directed sequences, readback vector tables and a random
// run, all compared against a queue-based model of captured samples.
module tb_da_capture_buf;
  localparam int unsigned DW = 8, DEPTH = 8, AW = 4, NCH = 2, CW = 2;

  logic              dack = 1'b0;
  logic              reset_n;
  logic              we, mode, arm, trig, stop, clr, rd_req;
  logic [NCH*DW-1:0] din;
  logic [NCH-1:0]    ch_en;
  logic [CW-1:0]     rd_ch;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     rd_data;
  logic              rd_valid, wrapped, overflow;
  logic [1:0]        state_o;
  logic [AW:0]       count;

  da_capture_buf #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .NCH(NCH), .CW(CW)) dut (
    .dack(dack), .reset_n(reset_n), .we(we), .din(din), .ch_en(ch_en), .mode(mode),
    .arm(arm), .trig(trig), .stop(stop), .clr(clr), .rd_req(rd_req), .rd_ch(rd_ch),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .state_o(state_o),
    .count(count), .wrapped(wrapped), .overflow(overflow)
  );

  always #5 dack = ~dack;

  int n_chk = 0;
  int n_fail = 0;

  // Model: state number, total writes since arm, samples kept oldest first
  int         m_state, m_total;
  bit         m_mode, m_ovf, m_rv;
  bit [1:0]   m_en;
  logic [7:0] m_rd;
  logic [7:0] m_q0[$], m_q1[$];

  typedef struct { int ch; int addr; logic [7:0] exp; } rb_vec_t;
  rb_vec_t rb1[9];
  rb_vec_t rb2[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_read(input int ch, input int addr);
    if (ch == 0 && m_en[0] && addr < m_q0.size()) return m_q0[addr];
    if (ch == 1 && m_en[1] && addr < m_q1.size()) return m_q1[addr];
    return 8'h00;
  endfunction

  task automatic m_reset();
    m_state = 0; m_total = 0; m_mode = 0; m_ovf = 0; m_rv = 0; m_en = '0; m_rd = '0;
    m_q0.delete(); m_q1.delete();
  endtask

  task automatic m_store();
    m_total++;
    m_q0.push_back(din[7:0]);
    m_q1.push_back(din[15:8]);
    if (m_q0.size() > int'(DEPTH)) begin
      void'(m_q0.pop_front());
      void'(m_q1.pop_front());
    end
  endtask

  // Advance the model by one sample-clock edge using the inputs currently applied
  task automatic model_step();
    if (m_state == 3 && rd_req) begin
      m_rv = 1;
      m_rd = m_read(int'(rd_ch), int'(rd_addr));
    end else begin
      m_rv = 0;
    end
    if (clr) begin
      m_state = 0; m_total = 0; m_ovf = 0;
      m_q0.delete(); m_q1.delete();
    end else begin
      case (m_state)
        0: if (arm) begin
             m_state = 1; m_en = ch_en; m_mode = mode; m_total = 0; m_ovf = 0;
             m_q0.delete(); m_q1.delete();
           end
        1: if (stop) m_state = 3;
           else if (trig) begin
             m_state = 2;
             if (we) m_store();
           end
        2: begin
             if (we) m_store();
             if (stop || (!m_mode && m_total >= int'(DEPTH))) m_state = 3;
           end
        default: if (we && !m_mode) m_ovf = 1;
      endcase
    end
  endtask

  task automatic cycle();
    int exp_cnt;
    model_step();
    @(posedge dack);
    #1;
    exp_cnt = (m_total > int'(DEPTH)) ? int'(DEPTH) : m_total;
    chk("state", 32'(state_o), 32'(m_state));
    chk("count", 32'(count), 32'(exp_cnt));
    chk("wrapped", 32'(wrapped), 32'(m_mode && m_total > int'(DEPTH)));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("rd_valid", 32'(rd_valid), 32'(m_rv));
    chk("rd_data", 32'(rd_data), 32'(m_rd));
    arm = 0; trig = 0; stop = 0; clr = 0; we = 0; rd_req = 0;
  endtask

  task automatic strobe(input logic [7:0] c0, input logic [7:0] c1);
    trig = 1; we = 1; din = {c1, c0};
    cycle();
  endtask

  task automatic read1(input int ch, input int addr);
    rd_req = 1; rd_ch = CW'(ch); rd_addr = AW'(addr);
    cycle();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      rb1[i] = '{ch: 1, addr: i, exp: 8'(8'h80 + i)};
      rb2[i] = '{ch: 0, addr: i, exp: 8'(5 + i)};
    end
    rb1[8] = '{ch: 1, addr: 8, exp: 8'h00};

    reset_n = 0; we = 0; mode = 0; arm = 0; trig = 0; stop = 0; clr = 0; rd_req = 0;
    din = '0; ch_en = '0; rd_ch = '0; rd_addr = '0;
    repeat (2) @(posedge dack);
    #1;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_flags", {30'd0, wrapped, overflow}, 0);
    chk("rst_rd", {23'd0, rd_valid, rd_data}, 0);
    m_reset();
    reset_n = 1;

    // One-shot fill and overflow
    ch_en = 2'b11; mode = 0; arm = 1; cycle();
    chk("os_armed", 32'(state_o), 1);
    for (int i = 0; i < 10; i++) begin
      strobe(8'(i), 8'(8'h80 + i));
      if (i == 7) begin
        chk("os_done", 32'(state_o), 3);
        chk("os_count", 32'(count), 8);
        chk("os_no_ovf", 32'(overflow), 0);
      end
      if (i == 8) chk("os_ovf", 32'(overflow), 1);
    end
    for (int i = 0; i < 9; i++) begin
      read1(rb1[i].ch, rb1[i].addr);
      chk("rb1_valid", 32'(rd_valid), 1);
      chk("rb1_data", 32'(rd_data), 32'(rb1[i].exp));
    end

    // Ring mode wrap, oldest first
    clr = 1; cycle();
    ch_en = 2'b11; mode = 1; arm = 1; cycle();
    for (int i = 0; i < 13; i++) strobe(8'(i), 8'(8'h80 + i));
    stop = 1; cycle();
    chk("ring_wrapped", 32'(wrapped), 1);
    chk("ring_count", 32'(count), 8);
    for (int i = 0; i < 8; i++) begin
      read1(rb2[i].ch, rb2[i].addr);
      chk("rb2_data", 32'(rd_data), 32'(rb2[i].exp));
    end

    // Partial channel enable
    clr = 1; cycle();
    ch_en = 2'b01; mode = 0; arm = 1; cycle();
    for (int i = 0; i < 3; i++) strobe(8'(8'h40 + i), 8'(8'hC0 + i));
    stop = 1; cycle();
    chk("en_count", 32'(count), 3);
    for (int i = 0; i < 3; i++) begin
      read1(0, i);
      chk("en_ch0", 32'(rd_data), 32'(8'h40 + i));
    end
    read1(1, 0);
    chk("en_ch1_zero", {23'd0, rd_valid, rd_data}, 32'h100);
    read1(2, 0);
    chk("en_ch2_zero", {23'd0, rd_valid, rd_data}, 32'h100);

    // trig+stop+we in ARMED, then clr beats arm
    clr = 1; cycle();
    ch_en = 2'b11; arm = 1; cycle();
    trig = 1; stop = 1; we = 1; din = 16'hAAAA; cycle();
    chk("ts_state", 32'(state_o), 3);
    chk("ts_count", 32'(count), 0);
    read1(0, 0);
    chk("ts_rd", {23'd0, rd_valid, rd_data}, 32'h100);
    clr = 1; arm = 1; cycle();
    chk("clr_arm", 32'(state_o), 0);

    // Asynchronous reset mid-capture
    arm = 1; cycle();
    for (int i = 0; i < 4; i++) strobe(8'(i), 8'(i));
    reset_n = 0;
    #2;
    chk("ar_state", 32'(state_o), 0);
    chk("ar_count", 32'(count), 0);
    chk("ar_rd", {22'd0, wrapped, overflow, rd_data}, 0);
    m_reset();
    #3;
    reset_n = 1;
    read1(0, 0);
    chk("ar_rdvalid", 32'(rd_valid), 0);

    // Readback refused during capture, then back-to-back in DONE
    ch_en = 2'b11; mode = 0; arm = 1; cycle();
    rd_req = 1; strobe(8'h22, 8'h11);
    rd_req = 1; strobe(8'h44, 8'h33);
    chk("cap_rdvalid", 32'(rd_valid), 0);
    stop = 1; cycle();
    read1(0, 0);
    chk("b2b0", {23'd0, rd_valid, rd_data}, 32'h122);
    read1(1, 1);
    chk("b2b1", {23'd0, rd_valid, rd_data}, 32'h133);
    read1(0, 2);
    chk("b2b2", {23'd0, rd_valid, rd_data}, 32'h100);
    cycle();
    chk("b2b_end", 32'(rd_valid), 0);

    // Random run against the model
    clr = 1; cycle();
    for (int n = 0; n < 3000; n++) begin
      arm     = ($urandom_range(99) < 15);
      trig    = ($urandom_range(99) < 30);
      stop    = ($urandom_range(99) < 5);
      clr     = ($urandom_range(99) < 3);
      we      = ($urandom_range(99) < 70);
      rd_req  = ($urandom_range(99) < 50);
      mode    = 1'($urandom);
      ch_en   = 2'($urandom);
      din     = 16'($urandom);
      rd_ch   = CW'($urandom);
      rd_addr = AW'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/da_capture_buf.md
Name: da_capture_buf

Overview:
- Parametrised, synthesisable successor to the single-channel D-A output capture model.
- Records NCH parallel D-A sample streams into per-channel on-chip buffers, clocked by the D-A sample clock.
- Supports armed/triggered start, one-shot and ring (continuous) modes, status flags, and a random-access readback port for the bench or host logic once capture has stopped.

Parameters:
- DW, 8, sample width per channel
- DEPTH, 910, samples per channel buffer; any value from 2 to 2**AW
- AW, 10, address/count width; must satisfy 2**AW >= DEPTH
- NCH, 2, number of channels; range 1 to 8
- CW, 3, channel-select width; must satisfy 2**CW >= NCH

Ports:
- dack  in  1  D-A sample clock; all logic on the rising edge
- reset_n  in  1  asynchronous active-low reset
- we  in  1  sample strobe; din is valid in this cycle
- din  in  NCH*DW  channel k occupies bits [k*DW +: DW]
- ch_en  in  NCH  per-channel capture enable, latched on arm
- mode  in  1  0 = one-shot, 1 = ring; latched on arm
- arm  in  1  pulse; IDLE -> ARMED
- trig  in  1  level; start capture while ARMED
- stop  in  1  pulse; end capture
- clr  in  1  pulse; return to IDLE, clear status
- rd_req  in  1  readback request
- rd_ch  in  CW  readback channel
- rd_addr  in  AW  logical sample index; 0 = oldest sample
- rd_data  out  DW  readback data
- rd_valid  out  1  rd_data valid
- state_o  out  2  0 = IDLE, 1 = ARMED, 2 = CAPTURE, 3 = DONE
- count  out  AW+1  samples held per channel; saturates at DEPTH
- wrapped  out  1  ring mode has overwritten data
- overflow  out  1  sticky; we seen in DONE in one-shot mode

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - state IDLE; write pointer, count, wrapped, overflow, rd_data, rd_valid and latched ch_en/mode all 0.
  - Buffer contents are not cleared.
- IDLE:
  - arm -> ARMED; latch ch_en and mode; clear pointer, count, wrapped and overflow.
  - All other inputs ignored.
- ARMED:
  - trig=1 -> CAPTURE. If we=1 in the same cycle, that sample is stored at index 0.
  - stop -> DONE with count = 0.
  - If trig and stop coincide, stop wins and no sample is stored.
- CAPTURE, each cycle with we=1:
  - Write din slice k to buffer k at the write pointer, for every latched-enabled channel only.
  - Pointer increments and wraps from DEPTH-1 to 0 (DEPTH need not be a power of 2).
  - count increments, saturating at DEPTH.
- CAPTURE, one-shot mode:
  - The write that makes count = DEPTH moves to DONE in the next state.
  - stop -> DONE immediately. If stop coincides with we, the sample is stored, then DONE.
- CAPTURE, ring mode:
  - Writes continue past DEPTH. The first write at pointer 0 after count = DEPTH sets wrapped.
  - Only stop -> DONE; a same-cycle we is stored.
- DONE:
  - In one-shot mode, we sets overflow (sticky); nothing is written.
  - In ring mode, DONE ignores we.
  - arm in DONE is ignored.
- clr in any state:
  - -> IDLE; count, wrapped and overflow cleared. Buffer keeps its data, so readback of a cleared capture is not guaranteed.
  - clr has priority over arm, trig and stop in the same cycle.
- Readback (IDLE excluded; DONE only):
  - rd_req=1 in DONE: the next cycle gives rd_valid=1 and rd_data (latency 1; back-to-back every cycle).
  - Physical address = rd_addr if wrapped=0, else (wptr + rd_addr) mod DEPTH.
  - rd_data = 0 (with rd_valid=1) when rd_addr >= count, rd_ch >= NCH, or the channel was not enabled.
  - rd_req in IDLE, ARMED or CAPTURE: rd_valid=0, rd_data held.
  - rd_valid is 0 in every cycle without an accepted request.
- Reset mid-capture takes effect immediately; no partial status survives.
- Arithmetic is unsigned throughout; the modulo add uses AW+1 bits before subtracting DEPTH.

Test Plan:
- DEPTH=8, NCH=2, ch_en=2'b11, mode=0: arm, trig, 10 strobes with din ch0=i, ch1=8'h80+i.
  - state DONE after the 8th write; count=8; overflow=1 after strobe 9.
  - Readback ch1 addr 0..7 = 80..87; addr 8 -> 0.
- Same setup, mode=1: 13 strobes with ch0=i, then stop.
  - wrapped=1, count=8.
  - Readback ch0 addr 0..7 = 5..12, i.e. oldest first across the wrap.
- ch_en=2'b01: capture 3 samples, then stop.
  - count=3; ch0 reads back the data; ch1 and rd_ch=2 return 0 with rd_valid=1.
- ARMED with trig, stop and we all 1 in one cycle.
  - DONE with count=0; readback addr 0 = 0.
  - clr together with arm -> IDLE, state_o=0.
- reset_n low for half a cycle after 4 captured samples.
  - All outputs return to 0 asynchronously; state IDLE.
  - rd_req afterwards gives rd_valid=0.
- rd_req during CAPTURE -> rd_valid=0.
  - In DONE, 3 consecutive rd_req -> rd_valid high for 3 cycles, each delayed by 1 cycle, with matching data.
